adc_spi_muestreo: RTL and testbench

//  Front-end stage feeding Filtro_Pasa_Baja_200_Hz. Generates the sample-rate tick and drives a 12-bit SPI ADC (AD7476-type, offset-binary output).

---
 rtl/adc_spi_muestreo.sv | 125 ++++++++++++
 tb/tb_adc_spi_muestreo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_muestreo.sv
// rtl/adc_spi_muestreo.sv - sample-rate tick, AD7476-type SPI capture and offset-binary to signed Uk conversion
// Optional feature macro: ADC_OVERRUN_EN (adds the sticky Overrun output)
module adc_spi_muestreo #(
  parameter int N          = 25,
  parameter int FRAC       = 16,
  parameter int CLK_DIV    = 4,
  parameter int SAMPLE_DIV = 10000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                ADC_SDATA,
  output logic                ADC_SCLK,
  output logic                ADC_CS_n,
  output logic signed [N-1:0] Uk,
  output logic                Bandera_ADC
`ifdef ADC_OVERRUN_EN
  ,
  output logic                Overrun
`endif
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, QUIET} state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic                   tick;
  logic [HW-1:0]          half_cnt;
  logic                   half_last;
  logic [3:0]             rise_cnt;
  // Only the 12 data bits are kept; the 4 leading frame bits shift out the top.
  logic [11:0]            shreg;
  logic signed [11:0]     samp;
  logic signed [N-1:0]    samp_ext;
  logic signed [N-1:0]    uk_next;

  assign tick      = Enable && (tick_cnt == TW'(SAMPLE_DIV - 1));
  assign half_last = (half_cnt == HW'(CLK_DIV - 1));

  // Offset binary to two's complement: invert the MSB, sign-extend, align to FRAC.
  assign samp     = {~shreg[11], shreg[10:0]};
  assign samp_ext = {{(N-12){samp[11]}}, samp};
  assign uk_next  = samp_ext <<< (FRAC - 11);

  // Sample-period counter, held at zero while sampling is disabled.
  always_ff @(posedge Clk) begin
    if (Reset || !Enable || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Frame sequencer: CS/SCLK generation, bit capture and sample publication.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      half_cnt    <= '0;
      rise_cnt    <= '0;
      shreg       <= '0;
      ADC_SCLK    <= 1'b1;
      ADC_CS_n    <= 1'b1;
      Uk          <= '0;
      Bandera_ADC <= 1'b0;
    end else begin
      Bandera_ADC <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            state    <= SHIFT;
            ADC_CS_n <= 1'b0;
            half_cnt <= '0;
            rise_cnt <= '0;
          end
        end
        SHIFT: begin
          if (half_last) begin
            half_cnt <= '0;
            ADC_SCLK <= ~ADC_SCLK;
            if (!ADC_SCLK) begin
              shreg    <= {shreg[10:0], ADC_SDATA};
              rise_cnt <= rise_cnt + 1'b1;
              if (rise_cnt == 4'd15) begin
                state <= DONE;
              end
            end
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        DONE: begin
          ADC_CS_n    <= 1'b1;
          Uk          <= uk_next;
          Bandera_ADC <= 1'b1;
          half_cnt    <= '0;
          state       <= QUIET;
        end
        QUIET: begin
          if (half_last) begin
            half_cnt <= '0;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_OVERRUN_EN
  // Sticky flag for any tick that arrives while a frame is still in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Overrun <= 1'b0;
    end else if (tick && (state != IDLE)) begin
      Overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adc_spi_muestreo.sv
// tb/tb_adc_spi_muestreo.sv - scoreboard bench for adc_spi_muestreo with an ADC serial model
module tb_adc_spi_muestreo;

`ifdef ADC_OVERRUN_EN
  localparam int SD = 100;
`else
  localparam int SD = 200;
`endif
  localparam int CD  = 4;
  localparam int LAT = 32 * CD + 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        ADC_SDATA = 1'b0;
  logic        ADC_SCLK;
  logic        ADC_CS_n;
  logic signed [24:0] Uk;
  logic        Bandera_ADC;
`ifdef ADC_OVERRUN_EN
  logic        Overrun;
`endif

  adc_spi_muestreo #(
    .N(25), .FRAC(16), .CLK_DIV(CD), .SAMPLE_DIV(SD)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Enable(Enable),
    .ADC_SDATA(ADC_SDATA),
    .ADC_SCLK(ADC_SCLK),
    .ADC_CS_n(ADC_CS_n),
    .Uk(Uk),
    .Bandera_ADC(Bandera_ADC)
`ifdef ADC_OVERRUN_EN
    ,
    .Overrun(Overrun)
`endif
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;

  always @(posedge Clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
  endtask

  logic [15:0] frame_q[$];
  logic [24:0] exp_q[$];

  // ADC model: next frame bit, MSB first, driven on every falling SCLK edge.
  logic [15:0] cur_frame = 16'h0;
  int          bit_idx = 15;
  always @(negedge ADC_CS_n) begin
    if (frame_q.size() > 0) cur_frame = frame_q.pop_front();
    else cur_frame = 16'h0;
    bit_idx = 15;
  end
  always @(negedge ADC_SCLK) begin
    if (ADC_CS_n === 1'b0 && bit_idx >= 0) begin
      ADC_SDATA = cur_frame[bit_idx];
      bit_idx--;
    end
  end

  // Monitor
  logic prev_cs = 1'b1, prev_sclk = 1'b1, prev_band = 1'b0, rst_prev = 1'b1;
  logic first_since_rst = 1'b1, have_prev = 1'b0;
  int   rises = 0, cs_fall_cyc = 0, last_pulse = 0, pulse_count = 0, first_pulse_cyc = -1;

  always @(negedge Clk) begin
    if (rst_prev) begin
      first_since_rst = 1'b1;
      have_prev = 1'b0;
    end
    if (prev_cs === 1'b1 && ADC_CS_n === 1'b0) begin
      rises = 0;
      cs_fall_cyc = cyc;
`ifdef ADC_OVERRUN_EN
      if (first_since_rst) check("overrun_clear_first_frame", {31'b0, Overrun}, 32'd0);
`endif
      first_since_rst = 1'b0;
    end
    if (ADC_CS_n === 1'b0 && prev_sclk === 1'b0 && ADC_SCLK === 1'b1) rises++;
    if (prev_cs === 1'b0 && ADC_CS_n === 1'b1 && !rst_prev) check("sclk_rises", rises, 16);
    if (Bandera_ADC === 1'b1) begin
      pulse_count++;
      check("no_back_to_back", {31'b0, prev_band}, 32'd0);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_pulse: got Uk %h expected no pulse at cycle %0d", Uk, cyc);
      end else begin
        check("uk", {7'b0, Uk}, {7'b0, exp_q.pop_front()});
      end
      check("cs_to_pulse_latency", cyc - cs_fall_cyc, LAT);
      if (have_prev) check("pulse_spacing", cyc - last_pulse, 200);
      have_prev = 1'b1;
      last_pulse = cyc;
      if (pulse_count == 1) first_pulse_cyc = cyc;
`ifdef ADC_OVERRUN_EN
      check("overrun_set", {31'b0, Overrun}, 32'd1);
`endif
    end
    prev_band = Bandera_ADC;
    prev_cs   = ADC_CS_n;
    prev_sclk = ADC_SCLK;
    rst_prev  = Reset;
  end

  logic [15:0] frames[10] = '{16'h0800, 16'h0FFF, 16'h0000, 16'hF801, 16'h07FF,
                              16'h0C00, 16'h0400, 16'hA001, 16'h5FFE, 16'h0A55};
  logic [24:0] exps[10]   = '{25'h0000000, 25'h000FFE0, 25'h1FF0000, 25'h0000020, 25'h1FFFFE0,
                              25'h0008000, 25'h1FF8000, 25'h1FF0020, 25'h000FFC0, 25'h0004AA0};

  initial begin
    int c0;
    int k;
    int pc0;

    // Reset held with sampling disabled
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("reset_state", {4'b0, Uk, Bandera_ADC, ADC_CS_n, ADC_SCLK}, {4'b0, 25'h0, 1'b0, 1'b1, 1'b1});
    end
`ifdef ADC_OVERRUN_EN
    check("reset_overrun", {31'b0, Overrun}, 32'd0);
`endif

    // Continuous sampling for 2000 enabled cycles
    for (int i = 0; i < 10; i++) begin
      frame_q.push_back(frames[i]);
      exp_q.push_back(exps[i]);
    end
    @(posedge Clk); #2;
    Reset = 1'b0;
    Enable = 1'b1;
    c0 = cyc;
    repeat (2000) @(posedge Clk);
    #2 Enable = 1'b0;
    repeat (300) @(posedge Clk);
    check("pulse_count", pulse_count, 10);
    check("first_pulse_cycle", first_pulse_cyc, c0 + SD + 129);
    check("expect_queue_drained", exp_q.size(), 0);

    // Reset in the middle of a frame, then a clean frame after restart
    frame_q.push_back(16'hFFFF);
    @(posedge Clk); #2;
    Enable = 1'b1;
    k = 0;
    while (ADC_CS_n !== 1'b0 && k < 400) begin
      @(posedge Clk); #2;
      k++;
    end
    if (k >= 400) begin
      total++;
      $display("FAIL cs_low_timeout: got CS_n %b expected 0 within 400 cycles", ADC_CS_n);
    end
    frame_q.push_back(16'h3123);
    exp_q.push_back(25'h1FF2460);
    pc0 = pulse_count;
    repeat (39) @(posedge Clk);
    #2 Reset = 1'b1;
    @(posedge Clk); #2;
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_state", {4'b0, Uk, Bandera_ADC, ADC_CS_n, ADC_SCLK}, {4'b0, 25'h0, 1'b0, 1'b1, 1'b1});
`ifdef ADC_OVERRUN_EN
    check("abort_overrun_cleared", {31'b0, Overrun}, 32'd0);
`endif
    k = 0;
    while (pulse_count == pc0 && k < 500) begin
      @(posedge Clk); #2;
      k++;
    end
    Enable = 1'b0;
    if (k >= 500) begin
      total++;
      $display("FAIL restart_pulse_timeout: got %0d pulses expected %0d", pulse_count - pc0, 1);
    end
    repeat (50) @(posedge Clk);
    check("restart_pulse_count", pulse_count - pc0, 1);
    check("restart_queue_drained", exp_q.size(), 0);
    check("uk_holds", {7'b0, Uk}, {7'b0, 25'h1FF2460});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
